ringy_dump_tx: RTL and testbench

//  Byte-serial frame transmitter: the readout end of the ringy accumulator/cell bank.
//  - On start, snapshots a 32-bit accumulator and a CELLS x 8-bit cell bank.
//  - Streams one framed packet over an 8-bit valid/ready byte interface, intended for the pin drivers.
//  - The packet lets an off-chip reader recover the full counter (not just cnt[31:24]) and every cell.

---
 rtl/ringy_dump_tx.sv | 199 +++++++++++++++++++
 tb/tb_ringy_dump_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ringy_dump_tx.sv
// ringy_dump_tx
//   Byte-serial readout of the ringy accumulator and cell bank. A start in IDLE
//   snapshots cnt_in and cells_in, then one frame is streamed over an 8-bit
//   valid/ready interface:
//     HDR, LEN=4+CELLS, cnt[31:24..7:0], cell0..cell(CELLS-1), SUM
//   SUM is (LEN + counter bytes + cells) mod 256; HDR is excluded.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset (release re-timed)
//   start            dump request, sampled only in IDLE
//   abort            drop current frame (priority over handshake)
//   cnt_in           32-bit accumulator to snapshot
//   cells_in         CELLS x 8-bit cell bank, cell i = cells_in[8*i+7:8*i]
//   tx_data/tx_valid byte source side of the handshake
//   tx_ready         sink accepts when tx_valid && tx_ready at posedge
//   busy             high while a frame is in flight
//   done             one-cycle pulse after SUM is accepted
module ringy_dump_tx #(
    parameter int unsigned CELLS = 10,
    parameter logic [7:0]  HDR   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          cnt_in,
    input  logic [8*CELLS-1:0]   cells_in,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned    IW        = $clog2(CELLS) + 1;
    localparam logic [7:0]     LEN_BYTE  = 8'(4 + CELLS);
    localparam logic [IW-1:0]  LAST_CELL = IW'(CELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_CNT,
        S_CELL,
        S_SUM
    } state_e;

    state_e               state_q, state_d;
    logic                 rst_sync_q;
    logic [1:0]           cidx_q, cidx_d;
    logic [IW-1:0]        kidx_q, kidx_d;
    logic [7:0]           sum_q, sum_d;
    logic                 done_q, done_d;
    logic [31:0]          cnt_q;
    logic [8*CELLS-1:0]   cells_q;
    logic                 load;
    logic                 hs;
    logic [7:0]           cnt_byte;
    logic [7:0]           cell_byte;

    // Reset release is re-timed: the FSM may only accept a start once this
    // flop has seen one clean edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cidx_q  <= '0;
            kidx_q  <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            cells_q <= '0;
        end else begin
            state_q <= state_d;
            cidx_q  <= cidx_d;
            kidx_q  <= kidx_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            if (load) begin
                cnt_q   <= cnt_in;
                cells_q <= cells_in;
            end
        end
    end

    assign tx_valid = (state_q != S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign hs       = tx_valid && tx_ready;

    always_comb begin
        cnt_byte = '0;
        case (cidx_q)
            2'd0:    cnt_byte = cnt_q[31:24];
            2'd1:    cnt_byte = cnt_q[23:16];
            2'd2:    cnt_byte = cnt_q[15:8];
            default: cnt_byte = cnt_q[7:0];
        endcase
    end

    always_comb begin
        cell_byte = '0;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (kidx_q == IW'(i)) begin
                cell_byte = cells_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        tx_data = '0;
        case (state_q)
            S_HDR:   tx_data = HDR;
            S_LEN:   tx_data = LEN_BYTE;
            S_CNT:   tx_data = cnt_byte;
            S_CELL:  tx_data = cell_byte;
            S_SUM:   tx_data = sum_q;
            default: tx_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cidx_d  = cidx_q;
        kidx_d  = kidx_q;
        done_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rst_sync_q && start && !abort) begin
                    state_d = S_HDR;
                    load    = 1'b1;
                    cidx_d  = '0;
                    kidx_d  = '0;
                end
            end
            S_HDR: begin
                if (hs) state_d = S_LEN;
            end
            S_LEN: begin
                if (hs) begin
                    state_d = S_CNT;
                    cidx_d  = '0;
                end
            end
            S_CNT: begin
                if (hs) begin
                    if (cidx_q == 2'd3) begin
                        state_d = S_CELL;
                        kidx_d  = '0;
                    end else begin
                        cidx_d = cidx_q + 2'd1;
                    end
                end
            end
            S_CELL: begin
                if (hs) begin
                    if (kidx_q == LAST_CELL) begin
                        state_d = S_SUM;
                    end else begin
                        kidx_d = kidx_q + IW'(1);
                    end
                end
            end
            S_SUM: begin
                if (hs) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides whatever the handshake decided above.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        sum_d = sum_q;
        if (load) begin
            sum_d = '0;
        end else if (hs && !abort &&
                     (state_q == S_LEN || state_q == S_CNT || state_q == S_CELL)) begin
            sum_d = sum_q + tx_data;
        end
    end

endmodule

// File: tb/tb_ringy_dump_tx.sv
module tb_ringy_dump_tx;

    localparam int unsigned CELLS = 10;
    localparam logic [7:0]  HDR   = 8'hA5;
    localparam int          FRAME = CELLS + 7;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 abort;
    logic [31:0]          cnt_in;
    logic [8*CELLS-1:0]   cells_in;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 busy;
    logic                 done;

    int errors = 0;
    int checks = 0;

    ringy_dump_tx #(.CELLS(CELLS), .HDR(HDR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .cnt_in   (cnt_in),
        .cells_in (cells_in),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    // The model only knows "a frame is a list of bytes; one leaves per
    // accepted handshake". It is clocked on the same edge as the DUT and
    // sampled on the opposite edge.
    logic [7:0] m_frame [FRAME];
    logic       m_act   = 1'b0;
    logic       m_done  = 1'b0;
    logic       m_ready = 1'b0;
    int         m_pos   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act   = 1'b0;
            m_done  = 1'b0;
            m_ready = 1'b0;
            m_pos   = 0;
        end else begin
            m_done = 1'b0;
            if (m_act) begin
                if (abort) begin
                    m_act = 1'b0;
                end else if (tx_ready) begin
                    if (m_pos == FRAME - 1) begin
                        m_act  = 1'b0;
                        m_done = 1'b1;
                    end else begin
                        m_pos++;
                    end
                end
            end else if (m_ready && start && !abort) begin
                int s;
                m_frame[0] = HDR;
                m_frame[1] = 8'(CELLS + 4);
                m_frame[2] = cnt_in[31:24];
                m_frame[3] = cnt_in[23:16];
                m_frame[4] = cnt_in[15:8];
                m_frame[5] = cnt_in[7:0];
                for (int i = 0; i < CELLS; i++) m_frame[6+i] = cells_in[8*i +: 8];
                s = 0;
                for (int i = 1; i < FRAME - 1; i++) s += m_frame[i];
                m_frame[FRAME-1] = 8'(s % 256);
                m_act = 1'b1;
                m_pos = 0;
            end
            m_ready = 1'b1;
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic      collect = 1'b0;
    logic [7:0] cap[$];
    int        busy_cycles = 0;

    always @(negedge clk) begin
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_act});
        chk("tx_data", {24'b0, tx_data}, {24'b0, (m_act ? m_frame[m_pos] : 8'h00)});
        chk("busy", {31'b0, busy}, {31'b0, m_act});
        chk("done", {31'b0, done}, {31'b0, m_done});
        if (collect) begin
            if (busy) busy_cycles++;
            if (tx_valid && tx_ready && !abort) cap.push_back(tx_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ref_inputs();
        cnt_in = 32'h12345678;
        for (int i = 0; i < CELLS; i++) cells_in[8*i +: 8] = 8'(i);
    endtask

    task automatic randomize_inputs();
        cnt_in = $urandom;
        for (int i = 0; i < CELLS; i++) cells_in[8*i +: 8] = 8'($urandom);
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
        if (!done) timeout_fail(name);
    endtask

    task automatic wait_pos(input string name, input int pos, input int limit);
        int n = 0;
        while (!(m_act && m_pos == pos) && n < limit) begin
            tick();
            n++;
        end
        if (!(m_act && m_pos == pos)) timeout_fail(name);
    endtask

    task automatic check_ref_frame(input string name);
        logic [7:0] exp_b [FRAME];
        exp_b[0] = 8'hA5; exp_b[1] = 8'h0E;
        exp_b[2] = 8'h12; exp_b[3] = 8'h34; exp_b[4] = 8'h56; exp_b[5] = 8'h78;
        for (int i = 0; i < CELLS; i++) exp_b[6+i] = 8'(i);
        exp_b[FRAME-1] = 8'h4F;
        chk({name, "_len"}, cap.size(), FRAME);
        for (int i = 0; i < FRAME && i < cap.size(); i++) begin
            chk({name, "_byte"}, {24'b0, cap[i]}, {24'b0, exp_b[i]});
        end
        // Pin the model's own frame builder to the same literal frame.
        for (int i = 0; i < FRAME; i++) begin
            chk({name, "_model"}, {24'b0, m_frame[i]}, {24'b0, exp_b[i]});
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        tx_ready = 1'b1;
        cnt_in   = '0;
        cells_in = '0;
        repeat (3) tick();
        chk("reset_valid", {31'b0, tx_valid}, 32'd0);
        chk("reset_data", {24'b0, tx_data}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: reference frame, ready always high
        set_ref_inputs();
        cap.delete();
        busy_cycles = 0;
        collect = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t1_done", 60);
        collect = 1'b0;
        check_ref_frame("t1");
        chk("t1_busy_cycles", busy_cycles, 17);
        tick();

        // 2: same stimulus, ready toggling
        cap.delete();
        collect = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 80 && !done; n++) begin
            tx_ready = ~tx_ready;
            tick();
        end
        if (!done) timeout_fail("t2_done");
        collect = 1'b0;
        tx_ready = 1'b1;
        check_ref_frame("t2");
        tick();

        // 3: inputs churn every cycle during the frame
        randomize_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 80 && !done; n++) begin
            randomize_inputs();
            tx_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        if (!done) timeout_fail("t3_done");
        tx_ready = 1'b1;
        tick();

        // 4: abort while third cell byte is presented
        set_ref_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pos("t4_pos", 8, 40);
        chk("t4_cell2", {24'b0, tx_data}, 32'h02);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_valid_after_abort", {31'b0, tx_valid}, 32'd0);
        chk("t4_busy_after_abort", {31'b0, busy}, 32'd0);
        for (int n = 0; n < 3; n++) begin
            chk("t4_no_done", {31'b0, done}, 32'd0);
            tick();
        end
        cap.delete();
        collect = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t4_done", 60);
        collect = 1'b0;
        check_ref_frame("t4");
        tick();

        // 5: start held through busy and done
        start = 1'b1;
        tick();
        wait_done("t5_done", 60);
        chk("t5_idle_gap_valid", {31'b0, tx_valid}, 32'd0);
        tick();
        chk("t5_second_hdr_valid", {31'b0, tx_valid}, 32'd1);
        chk("t5_second_hdr_data", {24'b0, tx_data}, {24'b0, HDR});
        start = 1'b0;
        wait_done("t5_done2", 60);
        tick();

        // 6: reset mid-CNT
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pos("t6_pos", 3, 40);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'b0, tx_valid}, 32'd0);
        chk("t6_async_data", {24'b0, tx_data}, 32'd0);
        chk("t6_async_busy", {31'b0, busy}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t6_idle_after_release", {31'b0, tx_valid}, 32'd0);

        // Random mix of start/abort/ready with churning inputs
        for (int n = 0; n < 600; n++) begin
            randomize_inputs();
            start    = ($urandom_range(0, 7) == 0);
            abort    = ($urandom_range(0, 29) == 0);
            tx_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        tx_ready = 1'b1;
        repeat (30) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
